// File: rtl/sram_multibank_ctrl.sv
// Controller for NUM_BANKS asynchronous SRAM chips behind one request port; upper address bits pick the bank.
// Optional read-modify-write byte masking is enabled by defining SRAM_MULTIBANK_CTRL_BYTE_MASK_EN.
module sram_multibank_ctrl #(
  parameter int NUM_BANKS = 2,
  parameter int BANK_AW   = 20,
  parameter int DW        = 32,
  parameter int RD_WAIT   = 1,
  parameter int WR_SETUP  = 1,
  parameter int WR_PULSE  = 1,
  parameter int WR_HOLD   = 1,
  localparam int BSW      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int AW       = BANK_AW + BSW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         req_we,
  input  logic [AW-1:0]                req_addr,
  input  logic [DW-1:0]                req_wdata,
`ifdef SRAM_MULTIBANK_CTRL_BYTE_MASK_EN
  input  logic [DW/8-1:0]              req_be,
`endif
  output logic                         req_ready,
  output logic                         rd_valid,
  output logic [DW-1:0]                rd_data,
  output logic                         wr_done,
  output logic [NUM_BANKS*BANK_AW-1:0] sram_addr,
  inout  wire  [NUM_BANKS*DW-1:0]      sram_data,
  output logic [NUM_BANKS-1:0]         sram_ce_n,
  output logic [NUM_BANKS-1:0]         sram_oe_n,
  output logic [NUM_BANKS-1:0]         sram_we_n
);

  localparam int MAX_RW = (RD_WAIT > WR_SETUP) ? RD_WAIT : WR_SETUP;
  localparam int MAX_PH = (WR_PULSE > WR_HOLD) ? WR_PULSE : WR_HOLD;
  localparam int MAXC   = (MAX_RW > MAX_PH) ? MAX_RW : MAX_PH;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  // RT is the bus turnaround between the read and write halves of a masked write.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RT   = 3'd2,
    WS   = 3'd3,
    WP   = 3'd4,
    WH   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BSW-1:0]       bank_q, bank_d;
  logic                 act_q, act_d;
  logic                 rmw_q, rmw_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [BANK_AW-1:0]   addr_q, addr_d;
  logic                 ready_q, ready_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_done_q, wr_done_d;
  logic [DW-1:0]        rd_data_q, rd_data_d;
  logic [NUM_BANKS-1:0] ce_n_q, ce_n_d;
  logic [NUM_BANKS-1:0] oe_n_q, oe_n_d;
  logic [NUM_BANKS-1:0] we_n_q, we_n_d;
  logic [NUM_BANKS-1:0] drv_q, drv_d;
`ifdef SRAM_MULTIBANK_CTRL_BYTE_MASK_EN
  logic [DW/8-1:0]      be_q, be_d;
`endif

  logic [BSW-1:0]       req_bank_s;
  logic                 bank_ok_s;
  logic [NUM_BANKS-1:0] sel_q_s;
  logic [NUM_BANKS-1:0] sel_d_s;
  logic [DW-1:0]        rd_bus_s;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BSW-1:0] idx, input logic en);
    logic [NUM_BANKS-1:0] oh;
    oh = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      oh[b] = en && (int'(idx) == b);
    end
    return oh;
  endfunction

`ifdef SRAM_MULTIBANK_CTRL_BYTE_MASK_EN
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] new_d, input logic [DW-1:0] old_d,
                                               input logic [DW/8-1:0] be);
    logic [DW-1:0] m;
    m = old_d;
    for (int i = 0; i < DW/8; i++) begin
      m[i*8 +: 8] = be[i] ? new_d[i*8 +: 8] : old_d[i*8 +: 8];
    end
    return m;
  endfunction
`endif

  // Request decode and the currently selected bank's read data.
  always_comb begin
    req_bank_s = req_addr[AW-1 -: BSW];
    bank_ok_s  = (int'(req_bank_s) < NUM_BANKS);
    sel_q_s    = bank_onehot(bank_q, act_q);
    rd_bus_s   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_bus_s = rd_bus_s | (sram_data[b*DW +: DW] & {DW{sel_q_s[b]}});
    end
  end

  // Transaction sequencing: next state, counter and latched request fields.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bank_d     = bank_q;
    act_d      = act_q;
    rmw_d      = rmw_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    ready_d    = ready_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
`ifdef SRAM_MULTIBANK_CTRL_BYTE_MASK_EN
    be_d       = be_q;
`endif
    case (state_q)
      IDLE: begin
        if (req && ready_q) begin
          bank_d  = req_bank_s;
          addr_d  = req_addr[BANK_AW-1:0];
          wdata_d = req_wdata;
          ready_d = 1'b0;
`ifdef SRAM_MULTIBANK_CTRL_BYTE_MASK_EN
          be_d    = req_be;
          // An empty mask still completes, but must never touch the chip.
          if (req_we && (req_be == '0)) begin
            act_d = 1'b0;
          end else begin
            act_d = bank_ok_s;
          end
          if (req_we && bank_ok_s && (req_be != '0) && (req_be != '1)) begin
            rmw_d = 1'b1;
          end else begin
            rmw_d = 1'b0;
          end
`else
          act_d   = bank_ok_s;
          rmw_d   = 1'b0;
`endif
          if (req_we && !rmw_d) begin
            state_d = WS;
            cnt_d   = CW'(WR_SETUP - 1);
          end else begin
            state_d = RD;
            cnt_d   = CW'(RD_WAIT - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (cnt_q == CW'(0)) begin
          if (rmw_q) begin
`ifdef SRAM_MULTIBANK_CTRL_BYTE_MASK_EN
            wdata_d = merge_bytes(wdata_q, rd_bus_s, be_q);
`endif
            state_d = RT;
          end else begin
            rd_data_d  = rd_bus_s;
            rd_valid_d = 1'b1;
            ready_d    = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RT: begin
        rmw_d   = 1'b0;
        state_d = WS;
        cnt_d   = CW'(WR_SETUP - 1);
      end
      WS: begin
        if (cnt_q == CW'(0)) begin
          state_d = WP;
          cnt_d   = CW'(WR_PULSE - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WP: begin
        if (cnt_q == CW'(0)) begin
          state_d = WH;
          cnt_d   = CW'(WR_HOLD - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WH: begin
        if (cnt_q == CW'(0)) begin
          wr_done_d = 1'b1;
          ready_d   = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Pin levels derived from the next state so that every SRAM control leaves a flop.
  always_comb begin
    sel_d_s = bank_onehot(bank_d, act_d);
    ce_n_d  = '1;
    oe_n_d  = '1;
    we_n_d  = '1;
    drv_d   = '0;
    case (state_d)
      IDLE: begin
        ce_n_d = '1;
      end
      RD: begin
        ce_n_d = ~sel_d_s;
        oe_n_d = ~sel_d_s;
      end
      RT: begin
        ce_n_d = ~sel_d_s;
      end
      WS, WH: begin
        ce_n_d = ~sel_d_s;
        drv_d  = sel_d_s;
      end
      WP: begin
        ce_n_d = ~sel_d_s;
        we_n_d = ~sel_d_s;
        drv_d  = sel_d_s;
      end
      default: begin
        ce_n_d = '1;
      end
    endcase
  end

  // State and output registers; reset releases the bus and all strobes at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bank_q     <= '0;
      act_q      <= 1'b0;
      rmw_q      <= 1'b0;
      wdata_q    <= '0;
      addr_q     <= '0;
      ready_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_data_q  <= '0;
      ce_n_q     <= '1;
      oe_n_q     <= '1;
      we_n_q     <= '1;
      drv_q      <= '0;
`ifdef SRAM_MULTIBANK_CTRL_BYTE_MASK_EN
      be_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      act_q      <= act_d;
      rmw_q      <= rmw_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      rd_data_q  <= rd_data_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      drv_q      <= drv_d;
`ifdef SRAM_MULTIBANK_CTRL_BYTE_MASK_EN
      be_q       <= be_d;
`endif
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bus
    assign sram_data[b*DW +: DW] = drv_q[b] ? wdata_q : {DW{1'bz}};
  end

  assign req_ready = ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign wr_done   = wr_done_q;
  assign sram_addr = {NUM_BANKS{addr_q}};
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;

endmodule
